muldiv_sequencer: RTL

- Iterative multi-cycle unsigned multiply/divide unit in the EX stage of the pipelined RV32 CPU; adds MUL, MULHU, DIVU and REMU beside the single-cycle ALU.
- Sequences shift-add multiplication and restoring division one bit per cycle.
- Drives a stall to the hazard logic so IF/ID/EX hold while it runs; honours pipeline flush from branch resolution.

---
 rtl/muldiv_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative unsigned multiply/divide unit for the EX stage of the RV32 pipeline.
// Implements MUL, MULHU, DIVU and REMU, one bit per clock:
//   - multiply: shift-add on a 2*XLEN product register (XLEN RUN cycles)
//   - divide:   restoring division on a remainder/quotient pair (XLEN RUN cycles)
// Division by zero bypasses RUN and produces the RISC-V defined results.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   EX holds a valid M-type instruction this cycle
//   op     in   00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b   in   rs1 / rs2 operands (already forwarded)
//   flush  in   kill any in-flight operation, return to IDLE
//   stall  out  hold IF/ID/EX while an operation is being accepted or run
//   busy   out  sequencer is iterating (RUN)
//   done   out  one-cycle pulse, result valid
//   result out  last completed result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [1:0]          op_r;
    logic [XLEN-1:0]     a_r, b_r;
    logic [2*XLEN-1:0]   prod_r;
    logic [XLEN-1:0]     rem_r, quo_r;
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     result_r;

    logic                load_s, step_s, finish_s, div0_s;
    logic [2*XLEN-1:0]   prod_nxt_s;
    logic [2*XLEN-1:0]   div_nxt_s;
    logic [XLEN-1:0]     result_nxt_s;
    logic [XLEN-1:0]     div0_res_s;

    // One shift-add step: conditional add into the upper half (carry kept in
    // the extra bit), then shift the whole product right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                   input logic [XLEN-1:0]   mcand);
        logic [XLEN:0]   hi;
        logic [2*XLEN:0] t;
        if (p[0]) begin
            hi = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, mcand};
        end else begin
            hi = {1'b0, p[2*XLEN-1:XLEN]};
        end
        t = {hi, p[XLEN-1:0]};
        return t[2*XLEN:1];
    endfunction

    // One restoring-division step. The running remainder is always below the
    // divisor, so the shifted value fits XLEN+1 bits and the kept difference
    // fits back into XLEN bits. Returns {remainder, quotient}.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                   input logic [XLEN-1:0] quo,
                                                   input logic [XLEN-1:0] dvs);
        logic [XLEN:0]   rs;
        logic [XLEN:0]   diff;
        logic [XLEN-1:0] qs;
        rs   = {rem, quo[XLEN-1]};
        qs   = {quo[XLEN-2:0], 1'b0};
        diff = rs - {1'b0, dvs};
        if (!diff[XLEN]) begin
            return {diff[XLEN-1:0], qs | {{(XLEN-1){1'b0}}, 1'b1}};
        end else begin
            return {rs[XLEN-1:0], qs};
        end
    endfunction

    // Next-state decode and datapath step control.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        div0_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (start) begin
                    if (op[1] && (b == {XLEN{1'b0}})) begin
                        state_nxt_s = DONE;
                        div0_s      = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                        load_s      = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == CW'(1)) begin
                        state_nxt_s = DONE;
                        finish_s    = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Step results and per-op result selection from the final step values.
    always_comb begin
        prod_nxt_s   = mul_step(prod_r, a_r);
        div_nxt_s    = div_step(rem_r, quo_r, b_r);
        result_nxt_s = {XLEN{1'b0}};
        case (op_r)
            OP_MUL:   result_nxt_s = prod_nxt_s[XLEN-1:0];
            OP_MULHU: result_nxt_s = prod_nxt_s[2*XLEN-1:XLEN];
            OP_DIVU:  result_nxt_s = div_nxt_s[XLEN-1:0];
            OP_REMU:  result_nxt_s = div_nxt_s[2*XLEN-1:XLEN];
            default:  result_nxt_s = {XLEN{1'b0}};
        endcase
        if (op[0]) begin
            div0_res_s = a;
        end else begin
            div0_res_s = {XLEN{1'b1}};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, iteration registers, counter and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 2'b00;
            a_r      <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            prod_r   <= {(2*XLEN){1'b0}};
            rem_r    <= {XLEN{1'b0}};
            quo_r    <= {XLEN{1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else begin
            if (load_s) begin
                op_r   <= op;
                a_r    <= a;
                b_r    <= b;
                prod_r <= {{XLEN{1'b0}}, b};
                rem_r  <= {XLEN{1'b0}};
                quo_r  <= a;
                cnt_r  <= CW'(XLEN);
            end
            if (step_s) begin
                prod_r <= prod_nxt_s;
                rem_r  <= div_nxt_s[2*XLEN-1:XLEN];
                quo_r  <= div_nxt_s[XLEN-1:0];
                cnt_r  <= cnt_r - CW'(1);
            end
            if (finish_s) begin
                result_r <= result_nxt_s;
            end
            if (div0_s) begin
                result_r <= div0_res_s;
            end
        end
    end

    // stall must rise in the accepting cycle, so it is decoded from inputs.
    assign stall  = ((state_r == IDLE) && start && !flush) || (state_r == RUN);
    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);
    assign result = result_r;

endmodule
